// File: rtl/seq_control_pkg.sv
// Shared definitions for the seq_control sequencer: opcode map, FSM state
// encoding and the ALU-op classifier used for flag updates.
package seq_control_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_LOAD  = 4'h4,
        OP_STORE = 4'h5,
        OP_IN    = 4'h6,
        OP_OUT   = 4'h7,
        OP_MOV   = 4'h8,
        OP_NOP   = 4'h9,
        OP_XOR   = 4'hA,
        OP_SHL   = 4'hB,
        OP_HALT  = 4'hC,
        OP_RSV_D = 4'hD,
        OP_RSV_E = 4'hE,
        OP_RSV_F = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_e;

    // Only these opcodes touch flag_z / flag_c.
    function automatic logic is_alu_op(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL};
    endfunction

endpackage

// File: rtl/seq_control_alu.sv
// Combinational ALU for seq_control: result, zero and carry/borrow from op, a, b.
// The extra MSB of 'wide' carries the ADD carry, SUB borrow or SHL shifted-out bit.
module seq_alu
    import seq_control_pkg::*;
#(
    parameter int DW = 8
) (
    input  opcode_e         op,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [DW-1:0]   result,
    output logic            zero,
    output logic            carry
);

    logic [DW:0] wide;

    always_comb begin
        // NOTE: 'wide' gets a value on every path (default arm), so no latch is inferred.
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_SHL:  wide = {a, 1'b0};
            default: wide = '0;
        endcase
    end

    assign result = wide[DW-1:0];
    assign carry  = wide[DW];
    assign zero   = (wide[DW-1:0] == '0);

endmodule

// File: rtl/seq_control.sv
// Single-issue sequencer: accepts one instruction in IDLE, executes it in EXEC,
// performs LOAD/STORE handshakes in MEM with a timeout, and parks in HALT.
module seq_control
    import seq_control_pkg::*;
#(
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int NREG = 4,
    parameter int TMO  = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [4+2*$clog2(NREG)-1:0]   instr,
    input  logic [DW-1:0]                 portin,
    output logic [DW-1:0]                 portout,
    output logic                          portout_valid,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    input  logic [DW-1:0]                 mem_rdata,
    input  logic                          mem_ack,
    output logic                          flag_z,
    output logic                          flag_c,
    output logic                          halted,
    output logic                          mem_err
);

    localparam int RSW = $clog2(NREG);
    localparam int IW  = 4 + 2*RSW;
    localparam int CW  = $clog2(TMO + 1);

    state_e          state, state_nxt;
    opcode_e         opc_q;
    logic [RSW-1:0]  rd_q, rs_q;
    logic [DW-1:0]   pin_q;
    logic [CW-1:0]   tmo_cnt;
    logic [DW-1:0]   regs [NREG];

    logic [DW-1:0]   alu_result;
    logic            alu_zero, alu_carry;
    logic            accept, mem_timeout;

    assign accept      = instr_valid && (state == ST_IDLE);
    assign mem_timeout = (tmo_cnt == CW'(TMO - 1));

    seq_alu #(.DW(DW)) u_alu (
        .op     (opc_q),
        .a      (regs[rd_q]),
        .b      (regs[rs_q]),
        .result (alu_result),
        .zero   (alu_zero),
        .carry  (alu_carry)
    );

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (instr_valid) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (opc_q == OP_LOAD || opc_q == OP_STORE) state_nxt = ST_MEM;
                else if (opc_q == OP_HALT)                 state_nxt = ST_HALT;
                else                                       state_nxt = ST_IDLE;
            end
            ST_MEM:  if (mem_ack || mem_timeout) state_nxt = ST_IDLE;
            default: state_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        instr_ready = (state == ST_IDLE);
        mem_req     = (state == ST_MEM);
        mem_we      = (state == ST_MEM) && (opc_q == OP_STORE);
        halted      = (state == ST_HALT);
        mem_addr    = pin_q[AW-1:0];
        mem_wdata   = regs[rd_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the register file is reset with everything else because its
            // contents after reset are architecturally visible (OUT, STORE).
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            opc_q         <= OP_NOP;
            rd_q          <= '0;
            rs_q          <= '0;
            pin_q         <= '0;
            portout       <= '0;
            portout_valid <= 1'b0;
            flag_z        <= 1'b0;
            flag_c        <= 1'b0;
            mem_err       <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            portout_valid <= 1'b0;

            if (accept) begin
                opc_q <= opcode_e'(instr[IW-1 -: 4]);
                rd_q  <= instr[2*RSW-1 -: RSW];
                rs_q  <= instr[RSW-1:0];
                pin_q <= portin;
            end

            if (state == ST_EXEC) begin
                if (is_alu_op(opc_q)) begin
                    regs[rd_q] <= alu_result;
                    flag_z     <= alu_zero;
                    flag_c     <= alu_carry;
                end
                case (opc_q)
                    OP_IN:   regs[rd_q] <= pin_q;
                    OP_MOV:  regs[rd_q] <= regs[rs_q];
                    OP_OUT: begin
                        portout       <= regs[rd_q];
                        portout_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // Ack wins over a timeout that would expire on the same cycle.
            if (state == ST_MEM) begin
                if (mem_ack) begin
                    if (opc_q == OP_LOAD) regs[rd_q] <= mem_rdata;
                    tmo_cnt <= '0;
                end else if (mem_timeout) begin
                    mem_err <= 1'b1;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control: transaction-level reference model with a
// per-cycle output comparator, directed corner cases, random traffic, and a
// DW=16/NREG=8 instance for the wide OUT path.
module tb_seq_control;

    localparam int DW   = 8;
    localparam int TMO  = 15;
    localparam int MASK = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  instr = '0;
    logic [7:0]  portin = '0;
    logic [7:0]  portout;
    logic        portout_valid;
    logic        mem_req, mem_we;
    logic [3:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        flag_z, flag_c, halted, mem_err;

    logic        w_instr_valid = 1'b0;
    logic        w_instr_ready;
    logic [9:0]  w_instr = '0;
    logic [15:0] w_portin = '0;
    logic [15:0] w_portout;
    logic        w_portout_valid;
    logic        w_mem_req, w_mem_we;
    logic [3:0]  w_mem_addr;
    logic [15:0] w_mem_wdata;
    logic        w_flag_z, w_flag_c, w_halted, w_mem_err;

    always #5 clk = ~clk;

    seq_control #(.DW(8), .AW(4), .NREG(4), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .portin(portin), .portout(portout), .portout_valid(portout_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .mem_err(mem_err)
    );

    seq_control #(.DW(16), .AW(4), .NREG(8), .TMO(TMO)) dut16 (
        .clk(clk), .rst(rst),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
        .portin(w_portin), .portout(w_portout), .portout_valid(w_portout_valid),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
        .mem_wdata(w_mem_wdata), .mem_rdata(16'h0000), .mem_ack(1'b0),
        .flag_z(w_flag_z), .flag_c(w_flag_c), .halted(w_halted), .mem_err(w_mem_err)
    );

    // Reference model: architectural registers plus the outputs expected right now.
    int         m_reg [4];
    logic       exp_ready, exp_halted, exp_req, exp_we, exp_err, exp_pv, exp_z, exp_c;
    logic [3:0] exp_addr;
    logic [7:0] exp_wdata, exp_portout;
    logic       chk_en = 1'b0;
    int         n_total = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_ready", 32'(instr_ready), 32'(exp_ready));
            check("halted", 32'(halted), 32'(exp_halted));
            check("mem_req", 32'(mem_req), 32'(exp_req));
            check("mem_err", 32'(mem_err), 32'(exp_err));
            check("portout_valid", 32'(portout_valid), 32'(exp_pv));
            check("portout", 32'(portout), 32'(exp_portout));
            check("flag_z", 32'(flag_z), 32'(exp_z));
            check("flag_c", 32'(flag_c), 32'(exp_c));
            if (exp_req) begin
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_pv = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 0;
        exp_ready = 1'b1; exp_halted = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
        exp_err = 1'b0; exp_pv = 1'b0; exp_z = 1'b0; exp_c = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_portout = '0;
    endtask

    task automatic alu_set(input int rd, input int val, input logic c);
        m_reg[rd] = val & MASK;
        exp_z = ((val & MASK) == 0);
        exp_c = c;
    endtask

    // Issues one instruction and runs it to completion against the model.
    // ack_at / rst_at: MEM cycle index carrying the ack / reset (-1 = never).
    task automatic exec_instr(input logic [3:0] op, input int rd, input int rs,
                              input logic [7:0] pin, input int ack_at,
                              input logic [7:0] rdata, input int rst_at,
                              output int mem_cycles);
        int a, b;
        mem_cycles = 0;
        instr_valid = 1'b1;
        instr = {op, 2'(rd), 2'(rs)};
        portin = pin;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
        step();
        instr_valid = 1'b0;
        instr = 8'($urandom);
        portin = 8'($urandom);
        mem_ack = 1'($urandom_range(0, 1));
        exp_ready = 1'b0;
        a = m_reg[rd];
        b = m_reg[rs];
        step();
        mem_ack = 1'b0;
        exp_ready = 1'b1;
        case (op)
            4'h0: alu_set(rd, a + b, (a + b) > MASK);
            4'h1: alu_set(rd, a - b, a < b);
            4'h2: alu_set(rd, a & b, 1'b0);
            4'h3: alu_set(rd, a | b, 1'b0);
            4'hA: alu_set(rd, a ^ b, 1'b0);
            4'hB: alu_set(rd, a << 1, a > (MASK >> 1));
            4'h6: m_reg[rd] = int'(pin);
            4'h8: m_reg[rd] = b;
            4'h7: begin exp_portout = 8'(a); exp_pv = 1'b1; end
            4'hC: begin exp_halted = 1'b1; exp_ready = 1'b0; end
            4'h4, 4'h5: begin
                exp_ready = 1'b0;
                exp_req = 1'b1;
                exp_we = (op == 4'h5);
                exp_addr = pin[3:0];
                exp_wdata = 8'(a);
                for (int k = 0; k < TMO; k++) begin
                    mem_cycles++;
                    if (k == rst_at) begin
                        mem_ack = 1'b1; mem_rdata = 8'($urandom); rst = 1'b1;
                        step();
                        rst = 1'b0; mem_ack = 1'b0;
                        model_reset();
                        return;
                    end
                    if (k == ack_at) begin
                        mem_ack = 1'b1; mem_rdata = rdata;
                        step();
                        mem_ack = 1'b0;
                        if (op == 4'h4) m_reg[rd] = int'(rdata);
                        exp_req = 1'b0; exp_ready = 1'b1;
                        return;
                    end
                    step();
                    if (k == TMO - 1) begin
                        exp_err = 1'b1; exp_req = 1'b0; exp_ready = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic w_issue(input logic [3:0] op, input int rd, input int rs, input logic [15:0] pin);
        w_instr_valid = 1'b1;
        w_instr = {op, 3'(rd), 3'(rs)};
        w_portin = pin;
        step();
        w_instr_valid = 1'b0;
        w_portin = 16'($urandom);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mc, r, ack_at;
        logic [3:0] op;

        // Reset state
        model_reset();
        step();
        step();
        chk_en = 1'b1;
        check("reset instr_ready", 32'(instr_ready), 32'h1);
        check("reset portout", 32'(portout), 32'h0);
        check("reset mem_req", 32'(mem_req), 32'h0);
        check("reset halted", 32'(halted), 32'h0);
        rst = 1'b0;
        step();
        check("ready after reset", 32'(instr_ready), 32'h1);

        // 0xFF + 0x01 wraps to zero with carry
        exec_instr(4'h6, 0, 0, 8'hFF, -1, 8'h00, -1, mc);
        exec_instr(4'h6, 1, 0, 8'h01, -1, 8'h00, -1, mc);
        exec_instr(4'h0, 0, 1, 8'h00, -1, 8'h00, -1, mc);
        check("add flag_z", 32'(flag_z), 32'h1);
        check("add flag_c", 32'(flag_c), 32'h1);
        exec_instr(4'h7, 0, 0, 8'h00, -1, 8'h00, -1, mc);
        check("add result r0", 32'(portout), 32'h00);
        check("out pulse", 32'(portout_valid), 32'h1);
        step();
        check("out pulse ends", 32'(portout_valid), 32'h0);

        // SUB r1,r1 -> zero, no borrow
        exec_instr(4'h1, 1, 1, 8'h00, -1, 8'h00, -1, mc);
        check("sub self flag_z", 32'(flag_z), 32'h1);
        check("sub self flag_c", 32'(flag_c), 32'h0);
        exec_instr(4'h6, 1, 0, 8'h01, -1, 8'h00, -1, mc);

        // STORE with ack after three wait cycles
        exec_instr(4'h6, 2, 0, 8'h3C, -1, 8'h00, -1, mc);
        exec_instr(4'h5, 2, 0, 8'h05, 3, 8'h00, -1, mc);
        check("store mem cycles", 32'(mc), 32'd4);
        check("store ready after ack", 32'(instr_ready), 32'h1);
        check("store mem_req dropped", 32'(mem_req), 32'h0);

        // LOAD that never gets acked
        exec_instr(4'h6, 3, 0, 8'h5A, -1, 8'h00, -1, mc);
        exec_instr(4'h4, 3, 0, 8'h09, -1, 8'hEE, -1, mc);
        check("timeout mem cycles", 32'(mc), 32'd15);
        check("timeout mem_err", 32'(mem_err), 32'h1);
        check("timeout ready", 32'(instr_ready), 32'h1);
        exec_instr(4'h7, 3, 0, 8'h00, -1, 8'h00, -1, mc);
        check("timeout rd unchanged", 32'(portout), 32'h5A);

        // OUT of 0xA5
        exec_instr(4'h6, 3, 0, 8'hA5, -1, 8'h00, -1, mc);
        exec_instr(4'h7, 3, 0, 8'h00, -1, 8'h00, -1, mc);
        check("out r3", 32'(portout), 32'hA5);

        // Reset coinciding with ack during a LOAD
        exec_instr(4'h4, 1, 0, 8'h03, -1, 8'h00, 1, mc);
        check("rst+ack mem_req", 32'(mem_req), 32'h0);
        check("rst+ack ready", 32'(instr_ready), 32'h1);
        exec_instr(4'h7, 1, 0, 8'h00, -1, 8'h00, -1, mc);
        check("rst+ack rd zero", 32'(portout), 32'h00);

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 3) == 0) step();
            op = 4'($urandom_range(0, 15));
            if (op == 4'hC) op = 4'h7;
            r = $urandom_range(0, 9);
            ack_at = (r == 0) ? -1 : (r == 1) ? TMO - 1 : $urandom_range(0, 4);
            exec_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom),
                       ack_at, 8'($urandom), -1, mc);
        end
        for (int i = 0; i < 4; i++) exec_instr(4'h7, i, 0, 8'h00, -1, 8'h00, -1, mc);

        // HALT with instructions still being offered
        exec_instr(4'hC, 0, 0, 8'h00, -1, 8'h00, -1, mc);
        for (int i = 0; i < 10; i++) begin
            instr_valid = 1'b1;
            instr = 8'($urandom);
            portin = 8'($urandom);
            mem_ack = 1'($urandom_range(0, 1));
            step();
        end
        check("halt halted", 32'(halted), 32'h1);
        check("halt ready", 32'(instr_ready), 32'h0);
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        step();
        check("halt cleared by rst", 32'(halted), 32'h0);

        // Wide instance: DW=16, NREG=8
        check("w reset ready", 32'(w_instr_ready), 32'h1);
        w_issue(4'h6, 3, 0, 16'h00A5);
        w_issue(4'h7, 3, 0, 16'h0000);
        check("w out r3", 32'(w_portout), 32'h00A5);
        check("w out pulse", 32'(w_portout_valid), 32'h1);
        step();
        check("w out pulse ends", 32'(w_portout_valid), 32'h0);
        w_issue(4'h6, 7, 0, 16'hBEEF);
        w_issue(4'h8, 5, 7, 16'h0000);
        w_issue(4'h0, 5, 7, 16'h0000);
        check("w add carry", 32'(w_flag_c), 32'h1);
        check("w add zero", 32'(w_flag_z), 32'h0);
        w_issue(4'h7, 5, 0, 16'h0000);
        check("w add result", 32'(w_portout), 32'h7DDE);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
